// File: rtl/dff_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter in front of the dff capture register.
package dff_arb_pkg;

  // Widest requester vector the onehot helper can produce.
  localparam int MAX_REQ = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // One-hot vector with bit idx set. The caller narrows the result to N_REQ bits.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [4:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: the first asserted request at or after ptr, wrapping.
import dff_arb_pkg::*;

module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     any,
  output logic [$clog2(N_REQ)-1:0] winner
);

  localparam int IDX_W = $clog2(N_REQ);

  int unsigned cand_s;

  // Scan offsets from the farthest to the nearest so the nearest asserted request wins.
  always_comb begin
    any    = 1'b0;
    winner = ptr;
    cand_s = 32'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand_s = 32'(ptr) + 32'(i);
      if (cand_s >= 32'(N_REQ)) begin
        cand_s = cand_s - 32'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (req[cand_s[IDX_W-1:0]]) begin
        any    = 1'b1;
        winner = cand_s[IDX_W-1:0];
      end else begin
        any    = any;
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/dff_rr_arbiter.sv
// Round-robin arbiter that owns the shared capture register and holds each grant for a bounded time.
import dff_arb_pkg::*;

module dff_rr_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*DATA_W-1:0] i_data,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [DATA_W-1:0]       o_q,
  output logic                    o_q_valid,
  output logic                    o_busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  arb_state_e          state_r;
  logic [IDX_W-1:0]    ptr_r;
  logic [IDX_W-1:0]    gnt_idx_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [N_REQ-1:0]    gnt_r;
  logic [DATA_W-1:0]   q_r;
  logic                q_valid_r;
  logic                busy_r;

  logic                any_s;
  logic [IDX_W-1:0]    winner_s;
  logic [IDX_W-1:0]    ptr_next_s;
  logic [DATA_W-1:0]   lane_s;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (i_req),
    .ptr    (ptr_r),
    .any    (any_s),
    .winner (winner_s)
  );

  // Winner's data lane and the pointer value after it; wrap is an explicit compare so any N_REQ works.
  always_comb begin
    lane_s = i_data[int'(winner_s)*DATA_W +: DATA_W];
    if (winner_s == IDX_W'(N_REQ - 1)) begin
      ptr_next_s = {IDX_W{1'b0}};
    end else begin
      ptr_next_s = winner_s + IDX_W'(1);
    end
  end

  // Arbitration FSM: capture on grant, hold for at most HOLD_CYCLES, release early if the owner drops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= IDLE;
      ptr_r     <= {IDX_W{1'b0}};
      gnt_idx_r <= {IDX_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      gnt_r     <= {N_REQ{1'b0}};
      q_r       <= {DATA_W{1'b0}};
      q_valid_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          q_valid_r <= 1'b0;
          if (any_s) begin
            gnt_r     <= N_REQ'(onehot(5'(winner_s)));
            gnt_idx_r <= winner_s;
            q_r       <= lane_s;
            q_valid_r <= 1'b1;
            busy_r    <= 1'b1;
            ptr_r     <= ptr_next_s;
            cnt_r     <= CNT_W'(HOLD_CYCLES - 1);
            state_r   <= HOLD;
          end
        end
        HOLD: begin
          q_valid_r <= 1'b0;
          if ((cnt_r == {CNT_W{1'b0}}) || !i_req[gnt_idx_r]) begin
            gnt_r   <= {N_REQ{1'b0}};
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          gnt_r     <= {N_REQ{1'b0}};
          q_valid_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt     = gnt_r;
  assign o_q       = q_r;
  assign o_q_valid = q_valid_r;
  assign o_busy    = busy_r;

endmodule

// File: tb/tb_dff_rr_arbiter.sv
// Self-checking bench: a 4-requester and a 3-requester arbiter against a cycle-level behavioural model.
module tb_dff_rr_arbiter;

  localparam int HOLD = 3;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [3:0]  req4 = 4'd0;
  logic [31:0] data4 = 32'd0;
  logic [2:0]  req3 = 3'd0;
  logic [23:0] data3 = 24'd0;

  logic [3:0]  gnt4;
  logic [7:0]  q4;
  logic        qv4, busy4;
  logic [2:0]  gnt3;
  logic [7:0]  q3;
  logic        qv3, busy3;

  int checks = 0;
  int errors = 0;

  // Model state per DUT (0: four requesters, 1: three requesters).
  int         m_busy [2];
  int         m_idx  [2];
  int         m_held [2];
  int         m_ptr  [2];
  logic [7:0] m_q    [2];
  logic       m_qv   [2];

  always #5 clk = ~clk;

  dff_rr_arbiter #(.N_REQ(4), .DATA_W(8), .HOLD_CYCLES(HOLD)) dut4 (
    .i_clk(clk), .i_rst(i_rst), .i_req(req4), .i_data(data4),
    .o_gnt(gnt4), .o_q(q4), .o_q_valid(qv4), .o_busy(busy4)
  );

  dff_rr_arbiter #(.N_REQ(3), .DATA_W(8), .HOLD_CYCLES(HOLD)) dut3 (
    .i_clk(clk), .i_rst(i_rst), .i_req(req3), .i_data(data3),
    .o_gnt(gnt3), .o_q(q3), .o_q_valid(qv3), .o_busy(busy3)
  );

  // Next-cycle model: grants searched from ptr modulo n, held up to HOLD cycles counted upward.
  task automatic model_step(input int u, input int n, input logic [3:0] req,
                            input logic [31:0] data, input logic rst);
    if (rst) begin
      m_busy[u] = 0; m_idx[u] = 0; m_held[u] = 0; m_ptr[u] = 0;
      m_q[u] = 8'd0; m_qv[u] = 1'b0;
    end else if (m_busy[u] == 0) begin
      m_qv[u] = 1'b0;
      for (int i = 0; i < n; i++) begin
        int c;
        c = (m_ptr[u] + i) % n;
        if (m_busy[u] == 0 && ((req >> c) & 4'd1) != 4'd0) begin
          m_busy[u] = 1;
          m_idx[u]  = c;
          m_held[u] = 1;
          m_q[u]    = 8'(data >> (c * 8));
          m_qv[u]   = 1'b1;
          m_ptr[u]  = (c + 1) % n;
        end
      end
    end else begin
      m_qv[u] = 1'b0;
      if (m_held[u] >= HOLD || ((req >> m_idx[u]) & 4'd1) == 4'd0) m_busy[u] = 0;
      else m_held[u] = m_held[u] + 1;
    end
  endtask

  // Drive one cycle of stimulus, advance the model, and compare all outputs of both DUTs.
  task automatic step(input logic rst, input logic [3:0] r4, input logic [31:0] d4,
                      input logic [2:0] r3, input logic [23:0] d3);
    logic [3:0] e_gnt4;
    logic [2:0] e_gnt3;
    @(negedge clk);
    i_rst = rst; req4 = r4; data4 = d4; req3 = r3; data3 = d3;
    model_step(0, 4, r4, d4, rst);
    model_step(1, 3, {1'b0, r3}, {8'h00, d3}, rst);
    e_gnt4 = (m_busy[0] != 0) ? 4'(1 << m_idx[0]) : 4'd0;
    e_gnt3 = (m_busy[1] != 0) ? 3'(1 << m_idx[1]) : 3'd0;
    @(posedge clk);
    #1;
    checks++;
    assert (gnt4 === e_gnt4) else begin
      errors++; $error("FAIL gnt4 observed=%b expected=%b t=%0t", gnt4, e_gnt4, $time);
    end
    checks++;
    assert (q4 === m_q[0]) else begin
      errors++; $error("FAIL q4 observed=%h expected=%h t=%0t", q4, m_q[0], $time);
    end
    checks++;
    assert (qv4 === m_qv[0]) else begin
      errors++; $error("FAIL q_valid4 observed=%b expected=%b t=%0t", qv4, m_qv[0], $time);
    end
    checks++;
    assert (busy4 === (m_busy[0] != 0)) else begin
      errors++; $error("FAIL busy4 observed=%b expected=%b t=%0t", busy4, (m_busy[0] != 0), $time);
    end
    checks++;
    assert (gnt3 === e_gnt3) else begin
      errors++; $error("FAIL gnt3 observed=%b expected=%b t=%0t", gnt3, e_gnt3, $time);
    end
    checks++;
    assert (q3 === m_q[1]) else begin
      errors++; $error("FAIL q3 observed=%h expected=%h t=%0t", q3, m_q[1], $time);
    end
    checks++;
    assert (qv3 === m_qv[1]) else begin
      errors++; $error("FAIL q_valid3 observed=%b expected=%b t=%0t", qv3, m_qv[1], $time);
    end
    checks++;
    assert (busy3 === (m_busy[1] != 0)) else begin
      errors++; $error("FAIL busy3 observed=%b expected=%b t=%0t", busy3, (m_busy[1] != 0), $time);
    end
  endtask

  initial begin
    logic [3:0] r4;
    logic [2:0] r3;

    // Reset held two cycles with every requester asserted.
    step(1'b1, 4'b1111, 32'hDEADBEEF, 3'b111, 24'h123456);
    step(1'b1, 4'b1111, 32'hDEADBEEF, 3'b111, 24'h123456);
    step(1'b0, 4'b0000, 32'h0, 3'b000, 24'h0);

    // Single requester 2 with lane 2 = A5, held six cycles: 3-cycle grant, gap, re-grant.
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0100, 32'h00A5_0000, 3'b100, 24'h5A_0000);
    step(1'b0, 4'b0000, 32'h0, 3'b000, 24'h0);
    step(1'b0, 4'b0000, 32'h0, 3'b000, 24'h0);

    // All requesting: fair rotation on both the power-of-2 and the 3-requester instance.
    for (int i = 0; i < 24; i++) step(1'b0, 4'b1111, 32'h44332211, 3'b111, 24'h332211);

    // Early release: requester 1 granted, drops after one cycle, requester 2 is next.
    step(1'b1, 4'b0000, 32'h0, 3'b000, 24'h0);
    step(1'b0, 4'b0010, 32'h0000_1100, 3'b010, 24'h00_1100);
    step(1'b0, 4'b0100, 32'h0022_0000, 3'b100, 24'h22_0000);
    step(1'b0, 4'b0100, 32'h0022_0000, 3'b100, 24'h22_0000);
    step(1'b0, 4'b0000, 32'h0, 3'b000, 24'h0);
    step(1'b0, 4'b0000, 32'h0, 3'b000, 24'h0);
    step(1'b0, 4'b0000, 32'h0, 3'b000, 24'h0);

    // Reset on the second hold cycle, then requester 3 wins from the reset pointer.
    step(1'b0, 4'b0001, 32'h0000_0077, 3'b001, 24'h00_0077);
    step(1'b0, 4'b0001, 32'h0000_0077, 3'b001, 24'h00_0077);
    step(1'b1, 4'b0001, 32'h0000_0077, 3'b001, 24'h00_0077);
    step(1'b0, 4'b1000, 32'h9900_0000, 3'b100, 24'h99_0000);
    step(1'b0, 4'b1000, 32'h9900_0000, 3'b100, 24'h99_0000);

    // Random sticky requests with fresh data and occasional resets.
    r4 = 4'd0;
    r3 = 3'd0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r4 = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r3 = 3'($urandom);
      step($urandom_range(0, 59) == 0, r4, $urandom, r3, 24'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_rr_arbiter.md
Name: dff_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one DFF-based capture register (DATA_W bits) between N_REQ requesters.
- The winning requester's data is loaded into the shared register, and the grant is held for a bounded number of cycles.
- Sits in front of the dff datapath. It is the only block allowed to write the shared register.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- DATA_W, 8, width of the shared register and of each requester data lane.
- HOLD_CYCLES, 3, maximum cycles a grant is held (>=1).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_req  input  N_REQ  per-requester request level.
- i_data  input  N_REQ*DATA_W  requester data; lane k is bits [k*DATA_W +: DATA_W].
- o_gnt  output  N_REQ  registered one-hot grant; all-zero when idle.
- o_q  output  DATA_W  shared register contents.
- o_q_valid  output  1  one-cycle pulse on the cycle o_q is newly loaded.
- o_busy  output  1  high while a grant is held.

Behaviour:
- Reset (i_rst sampled high at an edge):
  - o_gnt=0, o_q=0, o_q_valid=0, o_busy=0.
  - State=IDLE, priority pointer ptr=0, hold counter cnt=0.
  - Reset overrides everything, including mid-grant: the grant drops after that edge and o_q clears.
- States: IDLE, HOLD.
- Winner selection (combinational, in IDLE only):
  - First asserted i_req[k], searching k = ptr, ptr+1, ..., wrapping mod N_REQ.
- IDLE, i_req != 0 at an edge, all in that same edge:
  - o_gnt <= onehot(winner); o_q <= i_data lane winner; o_q_valid <= 1; o_busy <= 1.
  - ptr <= (winner+1) mod N_REQ; cnt <= HOLD_CYCLES-1; state <= HOLD.
  - Latency: request seen at edge k -> grant visible after edge k (1 cycle).
- IDLE, i_req == 0: outputs hold; o_q keeps its last value; o_q_valid=0.
- HOLD, every edge: o_q_valid <= 0; o_q does not change (no re-capture during the hold).
- HOLD release: if cnt==0 OR i_req[granted] is low at the edge:
  - o_gnt <= 0; o_busy <= 0; state <= IDLE.
  - Otherwise cnt <= cnt-1.
- Grant duration: at most HOLD_CYCLES cycles. Early release happens when the granted requester drops its request.
- Gap: at least one IDLE cycle between consecutive grants, so o_gnt is never asserted back-to-back without a zero cycle.
- Requests from non-granted requesters during HOLD are ignored. They are arbitrated in the next IDLE cycle.
- ptr advances only on a grant, not on release.
- Fairness: with all requesters continuously requesting, grant order is 0,1,2,...,N_REQ-1,0,...
- HOLD_CYCLES=1: cnt loads 0; the grant lasts exactly 1 cycle.
- Widths:
  - ptr and granted index: $clog2(N_REQ) bits; wrap via explicit compare to N_REQ-1, so non-power-of-2 N_REQ is supported.
  - cnt: $clog2(HOLD_CYCLES+1) bits.

Decomposition:
- Package dff_arb_pkg: state enum (IDLE, HOLD) and a function onehot(idx).
- Combinational sub-module rr_pick:
  - Inputs: req vector and ptr.
  - Outputs: any and winner index.
  - Parameterized by N_REQ.
- Top module holds the FSM, counter, pointer and the shared register.

Test Plan:
- Reset: i_rst=1 for 2 cycles with i_req=4'b1111 -> o_gnt=0, o_q=0, o_busy=0, o_q_valid=0 throughout.
- Single request: i_req=4'b0100, lane2=8'hA5, held 6 cycles, HOLD_CYCLES=3 -> after 1 edge: o_gnt=4'b0100, o_q=8'hA5, o_q_valid high for 1 cycle; o_gnt high 3 cycles, then 0 for 1 cycle, then re-grants lane 2.
- Round-robin: i_req=4'b1111 constant -> grant sequence 0,1,2,3,0; each grant 3 cycles plus a 1-cycle gap.
- Early release: requester 1 granted, drops i_req[1] after 1 cycle -> o_gnt=0 on the next edge; cnt does not reach 0; next grant goes to requester 2 if it is requesting.
- Reset mid-grant: i_rst pulsed on the 2nd HOLD cycle -> o_gnt=0, o_q=0 after that edge; with i_req=4'b1000, the next grant is requester 3 (ptr=0 search) after i_rst drops.
- Non-power-of-2: N_REQ=3, i_req=3'b111 -> order 0,1,2,0; ptr never reaches 3.
